bitsplit_ctrl: RTL and testbench

Sequencer for the even/odd serial-in parallel-out bit-splitter datapath. It accepts a gapless serial frame of 2*NIBBLE bits from upstream, steers alternate bits into the even and odd SIPO lanes, captures the two filled nibbles, and presents them downstream with a valid/ready handshake. It also owns clearing the SIPO between frames and detects upstream underrun.

---
 rtl/bitsplit_ctrl_if.sv | 24 ++
 rtl/bitsplit_ctrl.sv | 121 ++++++++++++
 tb/tb_bitsplit_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitsplit_ctrl_if.sv
// Handshake bundle for the bit-splitter sequencer: serial input stream on one
// side, captured even/odd nibbles with valid/ready on the other.
interface bitsplit_ctrl_if #(
  parameter int NIBBLE = 4
);
  logic              din;
  logic              din_valid;
  logic              din_ready;
  logic [NIBBLE-1:0] out_eve;
  logic [NIBBLE-1:0] out_odd;
  logic              out_valid;
  logic              out_ready;

  // master is the sequencer; slave is the upstream/downstream environment.
  modport master (
    input  din, din_valid, out_ready,
    output din_ready, out_eve, out_odd, out_valid
  );

  modport slave (
    output din, din_valid, out_ready,
    input  din_ready, out_eve, out_odd, out_valid
  );
endinterface

// File: rtl/bitsplit_ctrl.sv
// Sequencer for the even/odd SIPO bit-splitter: steers a 2*NIBBLE-bit serial
// frame into two lanes, captures both nibbles and hands them off downstream.
module bitsplit_ctrl #(
  parameter int NIBBLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  bitsplit_ctrl_if.master   bus,
  input  logic              start,
  output logic              dataeve,
  output logic              dataodd,
  output logic              outt,
  output logic              sipo_clr,
  input  logic [NIBBLE-1:0] sipo_eve,
  input  logic [NIBBLE-1:0] sipo_odd,
  output logic              busy,
  output logic              err_underrun,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int BCW = (2 * NIBBLE > 1) ? $clog2(2 * NIBBLE) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(2 * NIBBLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FILL,
    S_SETTLE,
    S_DRAIN
  } state_t;

  state_t         state;
  logic [BCW-1:0] bit_cnt;

  // Both lanes see the raw bit; outt decides which SIPO lane actually shifts.
  assign dataeve = bus.din;
  assign dataodd = bus.din;
  assign busy    = (state != S_IDLE);

  // NOTE: every register here is state, so all assignments are non-blocking;
  // a blocking write would let later statements see the new value mid-edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      outt          <= 1'b0;
      sipo_clr      <= 1'b1;
      bus.din_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_eve   <= '0;
      bus.out_odd   <= '0;
      err_underrun  <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      // NOTE: defaulting the strobe low each edge makes it a single-cycle pulse
      // without needing a separate clearing state.
      err_underrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ARM;
            sipo_clr <= 1'b0;
            bit_cnt  <= '0;
            outt     <= 1'b0;
          end
        end

        S_ARM: begin
          bit_cnt       <= '0;
          outt          <= 1'b0;
          bus.din_ready <= 1'b1;
          state         <= S_FILL;
        end

        S_FILL: begin
          if (bus.din_valid) begin
            bit_cnt <= bit_cnt + BCW'(1);
            outt    <= ~outt;
            if (bit_cnt == LAST_BIT) begin
              bus.din_ready <= 1'b0;
              state         <= S_SETTLE;
            end
          end else begin
            // Upstream broke the gapless frame: drop it and clear the lanes.
            err_underrun  <= 1'b1;
            sipo_clr      <= 1'b1;
            bus.din_ready <= 1'b0;
            state         <= S_IDLE;
          end
        end

        S_SETTLE: begin
          // The last bit has shifted in by now; capture both lanes.
          bus.out_eve   <= sipo_eve;
          bus.out_odd   <= sipo_odd;
          bus.out_valid <= 1'b1;
          state         <= S_DRAIN;
        end

        S_DRAIN: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            frame_cnt     <= frame_cnt + CNT_W'(1);
            sipo_clr      <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: begin
          state         <= S_IDLE;
          sipo_clr      <= 1'b1;
          bus.din_ready <= 1'b0;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitsplit_ctrl.sv
// Randomized self-checking bench for bitsplit_ctrl with a behavioural SIPO and
// a frame-level reference model of lane ordering and frame counting.
module tb_bitsplit_ctrl;

  localparam int NIBBLE = 4;
  localparam int CNT_W  = 8;
  localparam int FRAME  = 2 * NIBBLE;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              dataeve, dataodd, outt, sipo_clr;
  logic [NIBBLE-1:0] sipo_eve, sipo_odd;
  logic              busy, err_underrun;
  logic [CNT_W-1:0]  frame_cnt;

  bitsplit_ctrl_if #(.NIBBLE(NIBBLE)) bus ();

  bitsplit_ctrl #(.NIBBLE(NIBBLE), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .start        (start),
    .dataeve      (dataeve),
    .dataodd      (dataodd),
    .outt         (outt),
    .sipo_clr     (sipo_clr),
    .sipo_eve     (sipo_eve),
    .sipo_odd     (sipo_odd),
    .busy         (busy),
    .err_underrun (err_underrun),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural SIPO: right-shifting lanes filled at the MSB, cleared by sipo_clr.
  always @(posedge clk or posedge sipo_clr) begin
    if (sipo_clr) begin
      sipo_eve <= '0;
      sipo_odd <= '0;
    end else if (bus.din_ready && bus.din_valid) begin
      if (!outt) sipo_eve <= {dataeve, sipo_eve[NIBBLE-1:1]};
      else       sipo_odd <= {dataodd, sipo_odd[NIBBLE-1:1]};
    end
  end

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bit i lands in lane (i % 2) at nibble position i / 2.
  function automatic logic [2*NIBBLE-1:0] ref_lanes(input logic [FRAME-1:0] bits);
    logic [NIBBLE-1:0] e, o;
    e = '0;
    o = '0;
    for (int i = 0; i < FRAME; i++) begin
      if (i % 2 == 0) e[i / 2] = bits[i];
      else            o[i / 2] = bits[i];
    end
    return {o, e};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_clr"}, sipo_clr, 1);
    check({tag, "_dinrdy"}, bus.din_ready, 0);
    check({tag, "_oval"}, bus.out_valid, 0);
  endtask

  // Full frame; hold_cycles of out_ready=0 in DRAIN, optional ignored starts.
  task automatic run_frame(input logic [FRAME-1:0] bits, input int hold_cycles,
                           input bit poke_start, input bit full_check);
    logic [2*NIBBLE-1:0] exp;
    exp = ref_lanes(bits);
    bus.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (full_check) begin
      check("arm_busy", busy, 1);
      check("arm_dinrdy", bus.din_ready, 0);
      check("arm_clr", sipo_clr, 0);
    end
    tick();
    if (full_check) check("fill_dinrdy", bus.din_ready, 1);
    for (int i = 0; i < FRAME; i++) begin
      bus.din = bits[i];
      bus.din_valid = 1'b1;
      if (poke_start && i == 3) start = 1'b1;
      #1;
      if (full_check) begin
        check("fill_outt", outt, i % 2);
        check("fill_dataeve", dataeve, bits[i]);
      end
      tick();
      start = 1'b0;
    end
    bus.din_valid = 1'b0;
    if (full_check) begin
      check("settle_dinrdy", bus.din_ready, 0);
      check("settle_oval", bus.out_valid, 0);
    end
    tick();
    check("drain_oval", bus.out_valid, 1);
    check("out_eve", bus.out_eve, exp[NIBBLE-1:0]);
    check("out_odd", bus.out_odd, exp[2*NIBBLE-1:NIBBLE]);
    for (int k = 0; k < hold_cycles; k++) begin
      tick();
      check("hold_oval", bus.out_valid, 1);
      check("hold_eve", bus.out_eve, exp[NIBBLE-1:0]);
      check("hold_odd", bus.out_odd, exp[2*NIBBLE-1:NIBBLE]);
      check("hold_cnt", frame_cnt, model_cnt);
    end
    bus.out_ready = 1'b1;
    if (poke_start) start = 1'b1;
    tick();
    start = 1'b0;
    bus.out_ready = 1'b0;
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
    check("frame_cnt", frame_cnt, model_cnt);
    if (full_check) check_idle("done");
  endtask

  initial begin
    logic [FRAME-1:0] bits;
    reset = 1'b1;
    start = 1'b0;
    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_idle("rst");
    check("rst_outt", outt, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_err", err_underrun, 0);
    check("rst_eve", bus.out_eve, 0);
    reset = 1'b0;
    tick();

    // Directed frame, immediate ready, then the same frame with a 5-cycle stall.
    bits = 8'b0100_1101;
    run_frame(bits, 0, 1'b0, 1'b1);
    check("dir_eve", bus.out_eve, 4'b1011);
    check("dir_odd", bus.out_odd, 4'b0010);
    run_frame(bits, 5, 1'b0, 1'b1);

    // Underrun after bit 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.din = 1'($urandom_range(0, 1));
      bus.din_valid = 1'b1;
      tick();
    end
    bus.din_valid = 1'b0;
    tick();
    check("urun_err", err_underrun, 1);
    check_idle("urun");
    tick();
    check("urun_err_pulse", err_underrun, 0);
    check("urun_cnt", frame_cnt, model_cnt);
    bits = 8'hFF;
    run_frame(bits, 0, 1'b0, 1'b1);
    check("ff_eve", bus.out_eve, 4'b1111);
    check("ff_odd", bus.out_odd, 4'b1111);

    // start pulses during FILL and DRAIN must be ignored.
    run_frame(8'($urandom), 2, 1'b1, 1'b1);
    tick();
    check_idle("ign");
    check("ign_cnt", frame_cnt, model_cnt);

    // Asynchronous reset mid-FILL, while bit 5 is presented.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.din = 1'b1;
      bus.din_valid = 1'b1;
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    check_idle("arst");
    check("arst_outt", outt, 0);
    check("arst_cnt", frame_cnt, 0);
    check("arst_eve", bus.out_eve, 0);
    check("arst_odd", bus.out_odd, 0);
    bus.din_valid = 1'b0;
    model_cnt = 0;
    #1;
    reset = 1'b0;
    tick();
    run_frame(8'b0101_0101, 0, 1'b0, 1'b1);
    check("alt_eve", bus.out_eve, 4'b1111);
    check("alt_odd", bus.out_odd, 4'b0000);

    // Randomized frames with random stall lengths.
    for (int n = 0; n < 20; n++)
      run_frame(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);

    // Wrap: bring the counter to 255, then one more frame wraps it to 0.
    while (model_cnt != 255)
      run_frame(8'($urandom), 0, 1'b0, 1'b0);
    check("cnt_255", frame_cnt, 255);
    run_frame(8'($urandom), 0, 1'b0, 1'b1);
    check("cnt_wrap", frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
